// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and fetch-entry type for the fetch unit
package fetch_unit_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Low address bits that are forced to zero on every fetch address
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Word-align a byte address
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
      return addr & ~ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular fetch queue with push/pop/flush and occupancy count
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter logic [WIDTH-1:0] RESET_DATA = '0,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;

   // Entry storage: reset to a known value so the head is never X, written at the tail on push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_DATA;
         end
      end else if (!flush && push) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers and count; flush discards everything, pointers wrap naturally (DEPTH is a power of two)
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch PC sequencing feeding a small decode queue
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C     = CW'(FIFO_DEPTH);
   localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};
   localparam fetch_entry_t    RESET_ENTRY = '{pc: RESET_PC_AL, instr: NOP_INSTR};

   logic [XLEN-1:0] fpc;
   logic [CW-1:0]   count;
   logic            full;
   logic            push;
   logic            pop;
   fetch_entry_t    wr_entry;
   fetch_entry_t    head;

   // A full queue can still accept a new word when the head leaves in the same cycle
   assign full     = (count == DEPTH_C);
   assign id_valid = (count != '0);
   assign pop      = id_valid && id_ready && !redirect_valid;
   assign push     = !redirect_valid && (!full || pop);

   assign imem_addr = fpc;
   assign wr_entry  = '{pc: fpc, instr: imem_rdata};

   // Fetch PC: redirect beats sequential advance; wraps at the top of the address space
   always_ff @(posedge clk) begin
      if (rst) begin
         fpc <= RESET_PC_AL;
      end else if (redirect_valid) begin
         fpc <= align_pc(redirect_pc);
      end else if (push) begin
         fpc <= fpc + XLEN'(INSTR_BYTES);
      end
   end

   fetch_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .WIDTH      ($bits(fetch_entry_t)),
      .RESET_DATA (RESET_ENTRY)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count)
   );

   assign id_pc       = head.pc;
   assign id_instr    = head.instr;
   assign id_pc_plus4 = head.pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a queue model
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, redirect_valid, id_ready;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr, imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, id_pc_plus4;

   logic        rst2;
   logic [31:0] imem_addr2, imem_rdata2;
   logic        id_valid2;
   logic [31:0] id_instr2, id_pc2, id_pc_plus4_2;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mq[$];
   logic [31:0] mfpc;

   always #5 clk = ~clk;

   // Memory image: word i holds value i
   assign imem_rdata  = {2'b00, imem_addr[31:2]};
   assign imem_rdata2 = {2'b00, imem_addr2[31:2]};

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
      .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
      .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_pc_plus4(id_pc_plus4_2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("id_valid", {31'd0, id_valid}, {31'd0, mq.size() != 0});
      check("imem_addr", imem_addr, mfpc);
      check("no_x", {31'd0, ^{id_instr, id_pc, id_pc_plus4} === 1'bx}, 32'd0);
      if (mq.size() != 0) begin
         check("id_pc", id_pc, mq[0]);
         check("id_instr", id_instr, mq[0] >> 2);
         check("id_pc_plus4", id_pc_plus4, mq[0] + 32'd4);
      end
   endtask

   // Drive one cycle of inputs, advance the model by the fetch rules, then check after the edge
   task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      logic do_pop, do_push;
      rst = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      if (r) begin
         mq.delete();
         mfpc = 32'h0;
      end else if (rv) begin
         mq.delete();
         mfpc = {rpc[31:2], 2'b00};
      end else begin
         do_pop  = (mq.size() != 0) && rdy;
         do_push = (mq.size() < 4) || do_pop;
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(mfpc);
            mfpc = mfpc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst2 = 1'b1;
      // Reset state: empty queue, head holds the reset entry
      cycle(1, 0, 0, 0);
      cycle(1, 1, 32'h1234, 1);
      check("rst_pc", id_pc, 32'h0);
      check("rst_instr", id_instr, 32'h0000_0013);

      // Streaming with decode always ready
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

      // Stall until full, then one simultaneous push/pop
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
      check("stall_addr", imem_addr, 32'h10);
      check("stall_pc", id_pc, 32'h0);
      cycle(0, 0, 0, 1);
      check("full_pushpop_addr", imem_addr, 32'h14);
      check("full_pushpop_pc", id_pc, 32'h4);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1);

      // Redirect with three queued entries
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
      check("three_queued_addr", imem_addr, 32'hC);
      cycle(0, 1, 32'h0000_0043, 1);
      check("redir_valid", {31'd0, id_valid}, 32'd0);
      check("redir_addr", imem_addr, 32'h40);
      cycle(0, 0, 0, 1);
      check("redir_pc", id_pc, 32'h40);

      // Back-to-back redirects: only the last target is fetched
      cycle(0, 1, 32'h100, 1);
      cycle(0, 1, 32'h200, 1);
      cycle(0, 1, 32'h305, 0);
      cycle(0, 0, 0, 1);
      check("b2b_pc", id_pc, 32'h304);

      // Reset beats redirect with a full queue
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
      cycle(1, 1, 32'h800, 1);
      check("rst_over_redir_valid", {31'd0, id_valid}, 32'd0);
      check("rst_over_redir_addr", imem_addr, 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0),
               $urandom, ($urandom_range(3) != 0));
      end

      // Address wrap on the second instance
      rst2 = 1'b0;
      cycle(0, 0, 0, 1);
      check("wrap_valid0", {31'd0, id_valid2}, 32'd1);
      check("wrap_pc0", id_pc2, 32'hFFFF_FFF8);
      cycle(0, 0, 0, 1);
      check("wrap_pc1", id_pc2, 32'hFFFF_FFFC);
      check("wrap_plus4", id_pc_plus4_2, 32'h0);
      cycle(0, 0, 0, 1);
      check("wrap_pc2", id_pc2, 32'h0);
      check("wrap_instr2", id_instr2, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
